// File: rtl/display_scan_ctrl.sv
// display_scan_ctrl: 8-digit seven-segment scan controller with per-slot blanking and a digit mask
// Ports: clk, reset (async, active-high), enable (low = dark and frozen), dig_mask[7:0] (1 lets digit i light),
//        seq_sel[2:0] (registered digit index for the nibble mux), a[7:0] (registered active-low anodes),
//        tick (registered pulse on the edge where seq_sel advances).
// Optional build macro DISP_DIM_EN adds brightness[3:0] and a 4-bit PWM dimmer on the DRIVE phase.
module display_scan_ctrl #(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_CYC   = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] dig_mask,
`ifdef DISP_DIM_EN
  input  logic [3:0] brightness,
`endif
  output logic [2:0] seq_sel,
  output logic [7:0] a,
  output logic       tick
);
  localparam int W = $clog2(REFRESH_DIV);
  localparam logic [W-1:0] LAST  = W'(REFRESH_DIV - 1);
  localparam logic [W-1:0] BLANK = W'(BLANK_CYC);
  logic [W-1:0] div_cnt, div_nxt;
  logic [2:0]   seq_nxt;
  logic [7:0]   a_nxt;
  logic         wrap, lit;
`ifdef DISP_DIM_EN
  logic [3:0] pwm_cnt, pwm_nxt;
  always_ff @(posedge clk or posedge reset)
    if (reset) pwm_cnt <= '0;
    else       pwm_cnt <= pwm_nxt;
  assign pwm_nxt = enable ? pwm_cnt + 4'd1 : 4'd0;
  assign lit     = pwm_nxt < brightness;
`else
  assign lit = 1'b1;
`endif
  // Anodes are decoded from next-state counters so a and seq_sel change on the same edge.
  always_comb begin
    wrap    = enable && div_cnt == LAST;
    div_nxt = !enable || wrap ? '0 : div_cnt + 1'b1;
    seq_nxt = wrap ? seq_sel + 3'd1 : seq_sel;
    a_nxt   = enable && div_nxt >= BLANK && dig_mask[seq_nxt] && lit ? ~(8'b1 << seq_nxt) : 8'hFF;
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      div_cnt <= '0;
      seq_sel <= 3'd0;
      a       <= 8'hFF;
      tick    <= 1'b0;
    end else begin
      div_cnt <= div_nxt;
      seq_sel <= seq_nxt;
      a       <= a_nxt;
      tick    <= wrap;
    end
endmodule
